aes_ctrl: RTL

AES_CTRL -- requirements
Module: aes_ctrl

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_rcon_gen.sv | 41 ++++
 rtl/aes_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round controller: round count, FSM states
// and the round-constant table.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    LOAD,
    ROUND,
    DONE
  } state_t;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: steps forward by xtime, backward by table lookup,
// and can be preset to the first (01) or last (36) constant.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ld01,
  input  logic       ld36,
  input  logic       stepFwd,
  input  logic       stepRev,
  output logic [7:0] rcon
);

  logic [3:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcon <= '0;
      idx  <= '0;
    end else if (clr) begin
      rcon <= '0;
      idx  <= '0;
    end else if (ld01) begin
      rcon <= RCON[0];
      idx  <= '0;
    end else if (ld36) begin
      rcon <= RCON[NR-1];
      idx  <= 4'(NR - 1);
    end else if (stepFwd) begin
      rcon <= xtime(rcon);
      idx  <= idx + 4'd1;
    end else if (stepRev) begin
      // xtime has no cheap inverse, so the previous constant comes from the table
      rcon <= RCON[idx - 4'd1];
      idx  <= idx - 4'd1;
    end
  end

endmodule

// File: rtl/aes_ctrl.sv
// AES-128 iterative round controller. Decryption (key expansion, reverse key
// schedule) is built only when AES_CTRL_DECRYPT_EN is defined.
module aes_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       inv,
  input  logic       key_new,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       dp_load,
  output logic       dp_key_load,
  output logic       dp_round_en,
  output logic [3:0] dp_round_idx,
  output logic       dp_final,
  output logic       dp_inv,
  output logic       dp_key_step,
  output logic       dp_key_dir,
  output logic [7:0] rcon,
  output logic       busy
);
  import aes_pkg::*;

`ifdef AES_CTRL_DECRYPT_EN
  localparam logic DEC_EN = 1'b1;
`else
  localparam logic DEC_EN = 1'b0;
`endif

  localparam logic [3:0] LAST = 4'(NR);

  state_t     state;
  logic [3:0] cnt;
  logic       kpos;
  logic       invQ;
  logic       invSel;
  logic       lastRnd;
  logic [3:0] nxtIdx;
  logic       rcClr, rcLd01, rcLd36, rcFwd, rcRev;

  assign invSel   = DEC_EN & inv;
  assign in_ready = rst_n && (state == IDLE);
  assign busy     = (state != IDLE);

  // rcon commands act on the coming edge so rcon lines up with the strobes
  always_comb begin
    rcClr   = 1'b0;
    rcLd01  = 1'b0;
    rcLd36  = 1'b0;
    rcFwd   = 1'b0;
    rcRev   = 1'b0;
    lastRnd = invQ ? (cnt == 4'd1) : (cnt == LAST);
    nxtIdx  = invQ ? (cnt - 4'd1) : (cnt + 4'd1);
    case (state)
      KEYEXP: begin
        if (cnt == '0)       rcLd01 = 1'b1;
        else if (cnt == LAST) rcClr = 1'b1;
        else                 rcFwd  = 1'b1;
      end
      LOAD: begin
        if (invQ) rcLd36 = 1'b1;
        else      rcLd01 = 1'b1;
      end
      ROUND: begin
        if (lastRnd)   rcClr = 1'b1;
        else if (invQ) rcRev = 1'b1;
        else           rcFwd = 1'b1;
      end
      default: rcClr = 1'b1;
    endcase
  end

  aes_rcon_gen uRcon (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (rcClr),
    .ld01    (rcLd01),
    .ld36    (rcLd36),
    .stepFwd (rcFwd),
    .stepRev (rcRev),
    .rcon    (rcon)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      kpos         <= 1'b0;
      invQ         <= 1'b0;
      out_valid    <= 1'b0;
      dp_load      <= 1'b0;
      dp_key_load  <= 1'b0;
      dp_round_en  <= 1'b0;
      dp_round_idx <= '0;
      dp_final     <= 1'b0;
      dp_inv       <= 1'b0;
      dp_key_step  <= 1'b0;
      dp_key_dir   <= 1'b0;
    end else begin
      dp_load      <= 1'b0;
      dp_key_load  <= 1'b0;
      dp_round_en  <= 1'b0;
      dp_round_idx <= '0;
      dp_final     <= 1'b0;
      dp_inv       <= 1'b0;
      dp_key_step  <= 1'b0;
      dp_key_dir   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            invQ   <= invSel;
            dp_inv <= invSel;
            cnt    <= '0;
            // a decrypt needs the last round key; expand unless it is already held
            if (invSel && (key_new || !kpos)) begin
              state       <= KEYEXP;
              dp_key_load <= 1'b1;
            end else begin
              state       <= LOAD;
              dp_load     <= 1'b1;
              dp_key_load <= ~invSel;
            end
          end
        end
        KEYEXP: begin
          dp_inv <= invQ;
          if (cnt == LAST) begin
            state   <= LOAD;
            dp_load <= 1'b1;
          end else begin
            cnt         <= cnt + 4'd1;
            dp_key_step <= 1'b1;
          end
        end
        LOAD: begin
          state        <= ROUND;
          cnt          <= invQ ? LAST : 4'd1;
          dp_round_idx <= invQ ? LAST : 4'd1;
          dp_round_en  <= 1'b1;
          dp_key_step  <= 1'b1;
          dp_key_dir   <= invQ;
          dp_final     <= invQ || (LAST == 4'd1);
          dp_inv       <= invQ;
        end
        ROUND: begin
          if (lastRnd) begin
            state     <= DONE;
            cnt       <= '0;
            kpos      <= ~invQ;
            out_valid <= 1'b1;
          end else begin
            cnt          <= nxtIdx;
            dp_round_idx <= nxtIdx;
            dp_round_en  <= 1'b1;
            dp_key_step  <= 1'b1;
            dp_key_dir   <= invQ;
            dp_final     <= !invQ && (nxtIdx == LAST);
            dp_inv       <= invQ;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
